pipe_stall_ctrl: RTL and testbench

- Generates the 6-bit pipeline stall vector consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Merges stage stall requests and owns a multi-cycle hold counter so EX-stage iterative units do not each need their own stall logic.
- Provides a stall-cycle performance counter and a stuck-pipeline watchdog flag.
- Sits beside the five pipeline stages at the top level of the CPU.

---
 rtl/pipe_stall_ctrl_if.sv | 29 ++
 rtl/pipe_stall_ctrl.sv | 81 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bundle: stage stall requests and multi-cycle hold control in,
// stall vector and status out. The master side is the pipeline, the slave side the controller.
interface pipe_stall_ctrl_if #(
   parameter int unsigned MC_W  = 6,
   parameter int unsigned CNT_W = 32
);
   logic             stallreq_from_id;
   logic             stallreq_from_ex;
   logic             stallreq_from_mem;
   logic             mc_start;
   logic [MC_W-1:0]  mc_cycles;
   logic             mc_cancel;
   logic [5:0]       stall;
   logic             mc_busy;
   logic [CNT_W-1:0] stall_cycles;
   logic             stall_timeout;

   modport master (
      output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      output mc_start, mc_cycles, mc_cancel,
      input  stall, mc_busy, stall_cycles, stall_timeout
   );

   modport slave (
      input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
      input  mc_start, mc_cycles, mc_cancel,
      output stall, mc_busy, stall_cycles, stall_timeout
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges stage stall requests, holds EX for multi-cycle ops,
// counts stalled cycles and flags a stuck pipeline.
module pipe_stall_ctrl #(
   parameter int unsigned MC_W      = 6,
   parameter int unsigned MAX_STALL = 64,
   parameter int unsigned CNT_W     = 32
) (
   input logic              clk,
   input logic              rst,
   pipe_stall_ctrl_if.slave bus
);
   localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);
   localparam logic [RUN_W-1:0] RunMax  = RUN_W'(MAX_STALL);
   localparam logic [RUN_W-1:0] RunTrip = RUN_W'(MAX_STALL - 1);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           state_q;
   logic [MC_W-1:0]  hold_q;
   logic [CNT_W-1:0] cnt_q;
   logic [RUN_W-1:0] run_q;
   logic             timeout_q;

   logic       mc_go;
   logic       ex_eff;
   logic [5:0] stall_vec;

   // A 0- or 1-cycle op completes within its issue cycle and needs no hold.
   assign mc_go  = (state_q == StIdle) && bus.mc_start && (bus.mc_cycles >= MC_W'(2));
   assign ex_eff = bus.stallreq_from_ex || ((state_q == StBusy) && !bus.mc_cancel) || mc_go;

   always_comb begin
      stall_vec = 6'b000000;
      if (!rst) begin
         if (bus.stallreq_from_mem)     stall_vec = 6'b011111;
         else if (ex_eff)               stall_vec = 6'b001111;
         else if (bus.stallreq_from_id) stall_vec = 6'b000111;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         hold_q    <= '0;
         cnt_q     <= '0;
         run_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mc_go) begin
                  hold_q  <= bus.mc_cycles - MC_W'(1);
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               if (bus.mc_cancel || (hold_q == MC_W'(1))) begin
                  hold_q  <= '0;
                  state_q <= StIdle;
               end else begin
                  hold_q <= hold_q - MC_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase

         if (stall_vec[0]) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
            if (run_q >= RunTrip)       timeout_q <= 1'b1;
            if (run_q != RunMax)        run_q <= run_q + RUN_W'(1);
         end else begin
            run_q <= '0;
         end
      end
   end

   assign bus.stall         = stall_vec;
   assign bus.mc_busy       = (state_q == StBusy);
   assign bus.stall_cycles  = cnt_q;
   assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized plus directed bench for pipe_stall_ctrl against a cycle-level behavioural model;
// a second instance with a 4-bit counter and short watchdog covers saturation.
module tb_pipe_stall_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.MC_W(6), .CNT_W(32)) bus_a ();
   pipe_stall_ctrl_if #(.MC_W(6), .CNT_W(4))  bus_b ();

   assign bus_b.stallreq_from_id  = bus_a.stallreq_from_id;
   assign bus_b.stallreq_from_ex  = bus_a.stallreq_from_ex;
   assign bus_b.stallreq_from_mem = bus_a.stallreq_from_mem;
   assign bus_b.mc_start          = bus_a.mc_start;
   assign bus_b.mc_cycles         = bus_a.mc_cycles;
   assign bus_b.mc_cancel         = bus_a.mc_cancel;

   pipe_stall_ctrl #(.MC_W(6), .MAX_STALL(64), .CNT_W(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   pipe_stall_ctrl #(.MC_W(6), .MAX_STALL(4), .CNT_W(4)) u_dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model state: remaining MC-held cycles, stalled-cycle counts and run lengths per instance.
   int     mc_left = 0;
   longint cnt_a = 0, cnt_b = 0;
   int     run_a = 0, run_b = 0;
   bit     to_a = 1'b0, to_b = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit i, input bit e, input bit m,
                       input bit s, input int n, input bit c);
      int         level;
      bit         mc_hold;
      logic [5:0] exp_stall;
      rst                     = r;
      bus_a.stallreq_from_id  = i;
      bus_a.stallreq_from_ex  = e;
      bus_a.stallreq_from_mem = m;
      bus_a.mc_start          = s;
      bus_a.mc_cycles         = n[5:0];
      bus_a.mc_cancel         = c;
      #1;
      mc_hold = (mc_left > 0) ? !c : (s && n >= 2);
      if (r)                 level = 0;
      else if (m)            level = 5;
      else if (e || mc_hold) level = 4;
      else if (i)            level = 3;
      else                   level = 0;
      exp_stall = 6'((1 << level) - 1);
      check("stall",         32'(bus_a.stall),         32'(exp_stall));
      check("mc_busy",       32'(bus_a.mc_busy),       32'(mc_left > 0));
      check("stall_cycles",  bus_a.stall_cycles,       cnt_a[31:0]);
      check("stall_timeout", 32'(bus_a.stall_timeout), 32'(to_a));
      check("sat_cycles",    32'(bus_b.stall_cycles),  cnt_b[31:0]);
      check("sat_timeout",   32'(bus_b.stall_timeout), 32'(to_b));
      @(posedge clk);
      if (r) begin
         mc_left = 0;
         cnt_a = 0; cnt_b = 0; run_a = 0; run_b = 0; to_a = 1'b0; to_b = 1'b0;
      end else begin
         if (mc_left > 0) mc_left = c ? 0 : mc_left - 1;
         else if (s && n >= 2) mc_left = n - 1;
         if (level > 0) begin
            if (cnt_a < 64'hFFFF_FFFF) cnt_a++;
            if (cnt_b < 15) cnt_b++;
            if (run_a >= 63) to_a = 1'b1;
            if (run_b >= 3)  to_b = 1'b1;
            if (run_a < 64) run_a++;
            if (run_b < 4)  run_b++;
         end else begin
            run_a = 0;
            run_b = 0;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int k);
      for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bus_a.stallreq_from_id  = 1'b0;
      bus_a.stallreq_from_ex  = 1'b0;
      bus_a.stallreq_from_mem = 1'b0;
      bus_a.mc_start          = 1'b0;
      bus_a.mc_cycles         = '0;
      bus_a.mc_cancel         = 1'b0;
      @(posedge clk);
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 1, 1, 1, 5, 0);

      // Single-source pulses and id+mem priority
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0);
      idle(2);

      // Five-cycle hold, then degenerate lengths
      step(0, 0, 0, 0, 1, 5, 0);
      idle(6);
      check("hold5_cycles", bus_a.stall_cycles, 32'd9);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 3, 1);
      idle(4);

      // Cancel mid-hold; restart while busy is ignored
      step(0, 0, 0, 0, 1, 8, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 3, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(5);
      step(0, 0, 0, 0, 1, 6, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      idle(6);

      // Watchdog trips on the 64th stalled edge and is sticky
      step(1, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 64; j++) step(0, 1, 0, 0, 0, 0, 0);
      idle(3);
      check("timeout_sticky", 32'(bus_a.stall_timeout), 32'd1);

      // Two 63-cycle runs split by a gap never trip
      step(1, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 63; j++) step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 63; j++) step(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      check("timeout_clear", 32'(bus_a.stall_timeout), 32'd0);

      // Saturation of the narrow counter
      step(1, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 20; j++) step(0, 1, 0, 0, 0, 0, 0);
      idle(1);
      check("sat_hold15", 32'(bus_b.stall_cycles), 32'd15);

      // Reset during a hold
      step(0, 0, 0, 0, 1, 10, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(3);

      for (int j = 0; j < 2000; j++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 7) == 0,   $urandom_range(0, 9) == 0,
              $urandom_range(0, 5) == 0,   int'($urandom_range(0, 12)),
              $urandom_range(0, 11) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
